// File: rtl/fex_pack.sv
// Shared widths, types and clamp helpers for the |x| / |x|^3 feature-extraction stage.
package fex_pack;
    localparam int FEX_DATA_W  = 14;
    localparam int FEX_FRAC_W  = 13;
    localparam int FEX_RAD_W   = 28;
    localparam int FEX_ROOT_W  = 14;
    localparam int FEX_LATENCY = 17;
    localparam int FEX_SAT_MAX = 8191;
    localparam int FEX_PROD_W  = FEX_ROOT_W + FEX_RAD_W;

    typedef logic signed [FEX_DATA_W-1:0] feat_t;
    typedef logic [FEX_RAD_W-1:0]         rad_t;

    function automatic logic fex_over(input logic [FEX_PROD_W-1:0] v);
        return v > FEX_PROD_W'(FEX_SAT_MAX);
    endfunction

    // Non-negative magnitude clamped into the positive Q1.13 range.
    function automatic feat_t fex_clamp(input logic [FEX_PROD_W-1:0] v);
        return fex_over(v) ? FEX_DATA_W'(FEX_SAT_MAX) : v[FEX_DATA_W-1:0];
    endfunction
endpackage

// File: rtl/fex_isqrt.sv
// Pipelined digit-by-digit integer square root: one root bit per stage, floor(sqrt(rad)).
// Radicand and a free-form sideband travel with each stage; all stages advance on en.
module fex_isqrt
    import fex_pack::*;
#(
    parameter int SB_W = 2 * FEX_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  en,
    input  logic                  in_valid,
    input  rad_t                  in_rad,
    input  logic [SB_W-1:0]       in_sb,
    output logic                  out_valid,
    output logic [FEX_ROOT_W-1:0] out_root,
    output rad_t                  out_rad,
    output logic [SB_W-1:0]       out_sb
);
    localparam int NST   = FEX_ROOT_W;
    localparam int REM_W = FEX_ROOT_W + 4;

    logic [NST-1:0]                 vld_reg, vld_next;
    logic [NST-1:0][REM_W-1:0]      rem_reg, rem_next;
    logic [NST-1:0][FEX_ROOT_W-1:0] root_reg, root_next;
    logic [NST-1:0][FEX_RAD_W-1:0]  rad_reg, rad_next;
    logic [NST-1:0][SB_W-1:0]       sb_reg, sb_next;

    genvar gi;
    generate
        for (gi = 0; gi < NST; gi++) begin : g_stage
            localparam int K = NST - 1 - gi;
            logic [REM_W-1:0]      rem_prev, rem_sh, trial;
            logic [FEX_ROOT_W-1:0] root_prev;
            logic                  take, unused_ok;

            if (gi == 0) begin : g_head
                assign vld_next[gi] = in_valid;
                assign rad_next[gi] = in_rad;
                assign sb_next[gi]  = in_sb;
                assign rem_prev     = '0;
                assign root_prev    = '0;
            end else begin : g_body
                assign vld_next[gi] = vld_reg[gi-1];
                assign rad_next[gi] = rad_reg[gi-1];
                assign sb_next[gi]  = sb_reg[gi-1];
                assign rem_prev     = rem_reg[gi-1];
                assign root_prev    = root_reg[gi-1];
            end

            // Bring down the next radicand bit pair and try root*4+1 against the remainder.
            assign rem_sh        = {rem_prev[REM_W-3:0], rad_next[gi][2*K+1 -: 2]};
            assign trial         = {2'b00, root_prev, 2'b01};
            assign take          = (rem_sh >= trial);
            assign rem_next[gi]  = take ? (rem_sh - trial) : rem_sh;
            assign root_next[gi] = {root_prev[FEX_ROOT_W-2:0], take};
            assign unused_ok     = ^{rem_prev[REM_W-1 -: 2], root_prev[FEX_ROOT_W-1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_reg <= '0;
        end else if (en) begin
            vld_reg <= vld_next;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            rem_reg  <= rem_next;
            root_reg <= root_next;
            rad_reg  <= rad_next;
            sb_reg   <= sb_next;
        end
    end

    logic unused_tail;
    assign unused_tail = ^rem_reg[NST-1];

    assign out_valid = vld_reg[NST-1];
    assign out_root  = root_reg[NST-1];
    assign out_rad   = rad_reg[NST-1];
    assign out_sb    = sb_reg[NST-1];
endmodule

// File: rtl/fex_abs13_taps.sv
// DPD input feature stage: per sample {I, Q, |x|, |x|^3} over a 3-deep tap history.
// Optional FEX_SAT_CNT_EN adds sat_count, counting emitted vectors with a clamped feature.
module fex_abs13_taps
    import fex_pack::*;
#(
    parameter int DATA_W       = FEX_DATA_W,
    parameter int FRAC_W       = FEX_FRAC_W,
    parameter int TAPS         = 3,
    parameter int FEAT_PER_TAP = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_W-1:0]             in_i,
    input  logic signed [DATA_W-1:0]             in_q,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TAPS*FEAT_PER_TAP*DATA_W-1:0]  out_feat
`ifdef FEX_SAT_CNT_EN
  , output logic [15:0]                          sat_count
`endif
);
    localparam int TAP_W = FEAT_PER_TAP * DATA_W;
    localparam int VEC_W = TAPS * TAP_W;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S0: latch the sample and its squared magnitude.
    logic                        s0_valid_reg;
    feat_t                       s0_i_reg, s0_q_reg;
    rad_t                        s0_r_reg;
    logic signed [FEX_RAD_W-1:0] i_ext, q_ext, r_sum;

    assign i_ext = FEX_RAD_W'(in_i);
    assign q_ext = FEX_RAD_W'(in_q);
    assign r_sum = i_ext * i_ext + q_ext * q_ext;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            s0_valid_reg <= 1'b0;
        end else if (en) begin
            s0_valid_reg <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s0_i_reg <= in_i;
            s0_q_reg <= in_q;
            s0_r_reg <= rad_t'(r_sum);
        end
    end

    // S1..S14: square root with I/Q riding along.
    logic                        sq_valid;
    logic [FEX_ROOT_W-1:0]       sq_root;
    rad_t                        sq_rad;
    logic [2*FEX_DATA_W-1:0]     sq_sb;
    feat_t                       sq_i, sq_q;

    fex_isqrt #(.SB_W(2 * FEX_DATA_W)) u_isqrt (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .en        (en),
        .in_valid  (s0_valid_reg),
        .in_rad    (s0_r_reg),
        .in_sb     ({s0_i_reg, s0_q_reg}),
        .out_valid (sq_valid),
        .out_root  (sq_root),
        .out_rad   (sq_rad),
        .out_sb    (sq_sb)
    );

    assign sq_i = sq_sb[2*FEX_DATA_W-1 -: FEX_DATA_W];
    assign sq_q = sq_sb[FEX_DATA_W-1:0];

    // S15: |x|^3 uses the unclamped root so the cube tracks r exactly.
    logic [FEX_PROD_W-1:0] cube_full, root_ext;
    logic                  s15_valid_reg;
    feat_t                 s15_i_reg, s15_q_reg, s15_m_reg, s15_c_reg;

    assign root_ext  = FEX_PROD_W'(sq_root);
    assign cube_full = (root_ext * FEX_PROD_W'(sq_rad)) >> (2 * FRAC_W);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            s15_valid_reg <= 1'b0;
        end else if (en) begin
            s15_valid_reg <= sq_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s15_i_reg <= sq_i;
            s15_q_reg <= sq_q;
            s15_m_reg <= fex_clamp(root_ext);
            s15_c_reg <= fex_clamp(cube_full);
        end
    end

    // S16: history shifts only when a real sample arrives.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid <= 1'b0;
            out_feat  <= '0;
        end else if (en) begin
            out_valid <= s15_valid_reg;
            if (s15_valid_reg) begin
                out_feat <= {out_feat[VEC_W-TAP_W-1:0], s15_c_reg, s15_m_reg, s15_q_reg, s15_i_reg};
            end
        end
    end

`ifdef FEX_SAT_CNT_EN
    logic s15_sat_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            s15_sat_reg <= fex_over(root_ext) || fex_over(cube_full);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            sat_count <= '0;
        end else if (en && s15_valid_reg && s15_sat_reg && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fex_abs13_taps.sv
// Self-checking bench: table-driven vectors and random streams feed a scoreboard of expected 12-element vectors.
module tb_fex_abs13_taps;
    import fex_pack::*;

    localparam int VEC_W = 3 * 4 * FEX_DATA_W;

    logic                    clk = 1'b0;
    logic                    rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic signed [13:0]      in_i, in_q;
    logic [VEC_W-1:0]        out_feat;
`ifdef FEX_SAT_CNT_EN
    logic [15:0]             sat_count;
`endif

    always #5 clk = ~clk;

    fex_abs13_taps dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_feat  (out_feat)
`ifdef FEX_SAT_CNT_EN
      , .sat_count (sat_count)
`endif
    );

    typedef struct {
        int i;
        int q;
        int m;
        int c;
        bit sat;
    } vec_t;

    vec_t             tbl[6];
    logic [VEC_W-1:0] exp_q[$];
    bit               sat_q[$];
    logic [VEC_W-1:0] model_vec;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_vec   = 0;
    int               sat_exp = 0;

    // Reference: exact integer sqrt and cube from the arithmetic definition.
    function automatic void ref_mc(input int i, input int q, output int m, output int c, output bit sat);
        longint r, s, cf;
        r = longint'(i) * i + longint'(q) * q;
        s = longint'($floor($sqrt(real'(r))));
        while (s * s > r) s--;
        while ((s + 1) * (s + 1) <= r) s++;
        cf  = (s * r) >> 26;
        m   = (s > 8191) ? 8191 : int'(s);
        c   = (cf > 8191) ? 8191 : int'(cf);
        sat = (s > 8191) || (cf > 8191);
    endfunction

    task automatic push_model(input int i, input int q, input int m, input int c, input bit sat);
        model_vec = {model_vec[VEC_W-57:0], 14'(c), 14'(m), 14'(q), 14'(i)};
        exp_q.push_back(model_vec);
        sat_q.push_back(sat);
    endtask

    task automatic clear_model();
        exp_q.delete();
        sat_q.delete();
        model_vec = '0;
        sat_exp   = 0;
    endtask

    task automatic check_out();
        logic [VEC_W-1:0] exp;
        bit               s;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vector got=%h required=none", out_feat);
        end else begin
            exp = exp_q.pop_front();
            s   = sat_q.pop_front();
            if (s) sat_exp++;
            n_vec++;
            if (out_feat !== exp) begin
                n_fail++;
                $display("FAIL vector_%0d got=%h required=%h", n_vec, out_feat, exp);
            end else begin
                $display("[TB] vector %0d tap0 I=%0d Q=%0d m=%0d c=%0d", n_vec,
                         $signed(out_feat[13:0]), $signed(out_feat[27:14]),
                         $signed(out_feat[41:28]), $signed(out_feat[55:42]));
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then pass the rising edge.
    task automatic step(input bit v, input int i, input int q, input bit ordy, input int m, input int c, input bit sat);
        bit acc;
        in_valid  = v;
        in_i      = 14'(i);
        in_q      = 14'(q);
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) check_out();
        acc = in_valid && in_ready && rst_n && !flush;
        if (acc) push_model(i, q, m, c, sat);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            idle(1);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            idle(1);
            lat++;
        end
        n_tests++;
        if (lat + 1 != FEX_LATENCY) begin
            n_fail++;
            $display("FAIL latency_%s got=%0d required=%0d", name, lat + 1, FEX_LATENCY);
        end
    endtask

    task automatic check_sat(input string name);
`ifdef FEX_SAT_CNT_EN
        n_tests++;
        if (int'(sat_count) != sat_exp) begin
            n_fail++;
            $display("FAIL sat_count_%s got=%0d required=%0d", name, sat_count, sat_exp);
        end
`else
        if (name.len() == 0) $display("[TB] sat check skipped");
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m, c;
        bit  sat, v;
        logic [VEC_W-1:0] prev;

        tbl[0] = '{i: 4096,  q: 0,     m: 4096, c: 1024, sat: 1'b0};
        tbl[1] = '{i: 3000,  q: 4000,  m: 5000, c: 1862, sat: 1'b0};
        tbl[2] = '{i: -8192, q: -8192, m: 8191, c: 8191, sat: 1'b1};
        tbl[3] = '{i: 1000,  q: 0,     m: 1000, c: 14,   sat: 1'b0};
        tbl[4] = '{i: 2000,  q: 0,     m: 2000, c: 119,  sat: 1'b0};
        tbl[5] = '{i: 3000,  q: 0,     m: 3000, c: 402,  sat: 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_i = '0; in_q = '0;
        clear_model();
        repeat (3) @(negedge clk);

        n_tests += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        if (out_feat !== '0)    begin n_fail++; $display("FAIL reset_out_feat got=%h required=0", out_feat); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        check_sat("reset");
        rst_n = 1'b1;

        // Single sample: latency and warm-up zeros in taps 1..2.
        step(1'b1, tbl[0].i, tbl[0].q, 1'b1, tbl[0].m, tbl[0].c, tbl[0].sat);
        measure_latency("first");
        drain("first");

        // Remaining table rows back-to-back; history carries on from row 0.
        for (int k = 1; k < 6; k++)
            step(1'b1, tbl[k].i, tbl[k].q, 1'b1, tbl[k].m, tbl[k].c, tbl[k].sat);
        drain("table");
        check_sat("table");

        // Random gaps with a 5-cycle output stall mid-stream.
        for (int n = 0; n < 40; n++) begin
            int  ri, rq;
            bit  ordy;
            ri   = int'($urandom_range(16383, 0)) - 8192;
            rq   = int'($urandom_range(16383, 0)) - 8192;
            v    = (n < 3) || ($urandom_range(3, 0) != 0);
            ordy = !(n >= 25 && n < 30);
            ref_mc(ri, rq, m, c, sat);
            prev = out_feat;
            step(v, ri, rq, ordy, m, c, sat);
            if (!ordy && out_valid) begin
                n_tests += 2;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle=%0d got=%b required=0", n, in_ready); end
                if (out_feat !== prev) begin n_fail++; $display("FAIL stall_hold cycle=%0d got=%h required=%h", n, out_feat, prev); end
            end
        end
        drain("random");
        check_sat("random");

        // Flush with 10 samples in flight; the sample offered in the flush cycle is dropped.
        for (int n = 0; n < 10; n++) begin
            ref_mc(500 * n, -300 * n, m, c, sat);
            step(1'b1, 500 * n, -300 * n, 1'b1, m, c, sat);
        end
        flush = 1'b1;
        step(1'b1, 777, 777, 1'b1, 0, 0, 1'b0);
        flush = 1'b0;
        clear_model();
        idle(25);
        n_tests += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b required=0", out_valid); end
        if (out_feat !== '0)    begin n_fail++; $display("FAIL flush_out_feat got=%h required=0", out_feat); end
        check_sat("flush");

        ref_mc(1234, -567, m, c, sat);
        step(1'b1, 1234, -567, 1'b1, m, c, sat);
        measure_latency("after_flush");
        drain("after_flush");
        check_sat("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
